// File: rtl/stim_resp_sequencer.sv
// rtl/stim_resp_sequencer.sv - LFSR stimulus generator with MISR response compaction
//
// Drives pseudo-random stimulus vectors (data_in/control) to a block under test,
// holding each for PERIOD cycles, and folds the sampled response (data_out) into
// a 16-bit signature at the end of each vector.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   run request (accepted in IDLE or DONE)
//   data_out   in   4   response from the block under test
//   data_in    out  4   registered stimulus data
//   control    out  3   registered stimulus control
//   busy       out  1   run in progress
//   done       out  1   run complete, held until next start or reset
//   signature  out 16   response signature, final once done=1
//   vec_count  out  7   vectors captured in the current or last run
module stim_resp_sequencer #(
    parameter int          PERIOD  = 4,
    parameter int          NUM_VEC = 100,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  data_out,
    output logic [3:0]  data_in,
    output logic [2:0]  control,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [6:0]  vec_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] PH_LAST  = 8'(PERIOD - 1);
    localparam logic [6:0] VEC_LAST = 7'(NUM_VEC);

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] sig_q, sig_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [3:0]  data_in_q, data_in_d;
    logic [2:0]  control_q, control_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [6:0]  cnt_inc;
    assign cnt_inc = cnt_q + 7'd1;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        lfsr_d    = lfsr_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        data_in_d = data_in_q;
        control_d = control_q;
        busy_d    = busy_q;
        done_d    = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // First vector comes straight from the seed; the LFSR is
                    // pre-stepped so it already holds the second vector.
                    state_d   = RUN;
                    data_in_d = SEED[3:0];
                    control_d = SEED[6:4];
                    lfsr_d    = lfsr_step(SEED);
                    phase_d   = 8'd0;
                    cnt_d     = 7'd0;
                    sig_d     = 16'd0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                end
            end
            RUN: begin
                if (phase_q == PH_LAST) begin
                    sig_d = lfsr_step(sig_q) ^ {12'b0, data_out};
                    cnt_d = cnt_inc;
                    if (cnt_inc == VEC_LAST) begin
                        state_d   = DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        data_in_d = 4'd0;
                        control_d = 3'd0;
                    end else begin
                        data_in_d = lfsr_q[3:0];
                        control_d = lfsr_q[6:4];
                        lfsr_d    = lfsr_step(lfsr_q);
                        phase_d   = 8'd0;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            phase_q   <= 8'd0;
            lfsr_q    <= SEED;
            sig_q     <= 16'd0;
            cnt_q     <= 7'd0;
            data_in_q <= 4'd0;
            control_q <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            lfsr_q    <= lfsr_d;
            sig_q     <= sig_d;
            cnt_q     <= cnt_d;
            data_in_q <= data_in_d;
            control_q <= control_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign data_in   = data_in_q;
    assign control   = control_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;
    assign vec_count = cnt_q;

endmodule
